approx_adder_error_profiler: RTL and testbench

//   Exhaustive error-characterisation engine placed around a combinational approximate adder
//   (IN1/IN2 -> Out[WIDTH:0]). Drives every operand pair into the adder, samples its sum the same

---
 rtl/approx_adder_error_profiler.sv | 142 ++++++++++++++
 tb/tb_approx_adder_error_profiler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_error_profiler.sv
// Sweeps every operand pair through an external combinational approximate adder and
// accumulates error count, sum |e|, sum e^2 and the first worst-case vector.
module approx_adder_error_profiler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 2*WIDTH+1,
  parameter int ABS_W = 3*WIDTH+1,
  parameter int SQ_W  = 4*WIDTH+2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ABS_W-1:0] sum_abs_err,
  output logic [SQ_W-1:0]  sum_sq_err,
  output logic [WIDTH:0]   max_abs_err,
  output logic [WIDTH-1:0] worst_a,
  output logic [WIDTH-1:0] worst_b,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = 2*WIDTH;
  localparam int SQ1_W = 2*WIDTH+2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             drain_cnt;
  logic             idx_last;
  logic             run_start;
  logic             clr;

  // S0 (combinational around the external adder)
  logic [WIDTH:0]         exact0;
  logic signed [WIDTH+1:0] diff0;
  logic [WIDTH+1:0]       neg0;
  logic [WIDTH:0]         abs0;
  logic [SQ1_W-1:0]       sq0;

  // S1 registers
  logic                   v1;
  logic [WIDTH+1:0]       diff1;
  logic [WIDTH:0]         abs1;
  logic [SQ1_W-1:0]       sq1;
  logic [WIDTH-1:0]       a1, b1;

  assign idx_last  = (idx == '1);
  assign run_start = start && !abort && (state == S_IDLE || state == S_DONE);
  assign clr       = abort || run_start;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (idx_last) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == S_DRAIN) && !abort;
    end
  end

  // idx only advances in RUN and stops on the last vector, so it is already 0 in IDLE
  // and keeps the final operands through DRAIN and DONE.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (state == S_RUN && !idx_last) begin
      idx <= idx + 1'b1;
    end
  end

  assign op_a      = idx[WIDTH-1:0];
  assign op_b      = idx[IDX_W-1:WIDTH];
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_comb begin
    exact0 = {1'b0, op_a} + {1'b0, op_b};
    diff0  = $signed({1'b0, approx_sum}) - $signed({1'b0, exact0});
    neg0   = -diff0;
    abs0   = diff0[WIDTH+1] ? neg0[WIDTH:0] : diff0[WIDTH:0];
    sq0    = SQ1_W'(abs0) * SQ1_W'(abs0);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      v1    <= 1'b0;
      diff1 <= '0;
      abs1  <= '0;
      sq1   <= '0;
      a1    <= '0;
      b1    <= '0;
    end else begin
      v1    <= (state == S_RUN);
      diff1 <= diff0;
      abs1  <= abs0;
      sq1   <= sq0;
      a1    <= op_a;
      b1    <= op_b;
    end
  end

  // Strict greater-than keeps the first vector that reaches the maximum.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      max_abs_err <= '0;
      worst_a     <= '0;
      worst_b     <= '0;
    end else if (v1) begin
      err_count   <= err_count + CNT_W'(diff1 != '0);
      sum_abs_err <= sum_abs_err + ABS_W'(abs1);
      sum_sq_err  <= sum_sq_err + SQ_W'(sq1);
      if (abs1 > max_abs_err) begin
        max_abs_err <= abs1;
        worst_a     <= a1;
        worst_b     <= b1;
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_error_profiler.sv
// Bench: a WIDTH=4 instance driven from lookup-table adders (vector table, random tables,
// abort/reset sequences) and a WIDTH=8 instance sweeping a tied-zero adder in parallel.
module tb_approx_adder_error_profiler;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // WIDTH=4 instance
  logic        rst4, start4, abort4;
  logic [3:0]  op_a4, op_b4, worst_a4, worst_b4;
  logic [4:0]  approx4, max4;
  logic        busy4, done4;
  logic [8:0]  cnt4;
  logic [12:0] sabs4;
  logic [17:0] ssq4;
  logic [1:0]  st4;
  logic [4:0]  lut4 [256];

  assign approx4 = lut4[{op_b4, op_a4}];

  approx_adder_error_profiler #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .abort(abort4),
    .op_a(op_a4), .op_b(op_b4), .approx_sum(approx4),
    .busy(busy4), .done(done4),
    .err_count(cnt4), .sum_abs_err(sabs4), .sum_sq_err(ssq4),
    .max_abs_err(max4), .worst_a(worst_a4), .worst_b(worst_b4),
    .dbg_state(st4)
  );

  // WIDTH=8 instance, adder output tied to zero
  logic        rst8, start8, abort8;
  logic [7:0]  op_a8, op_b8, worst_a8, worst_b8;
  logic [8:0]  approx8, max8;
  logic        busy8, done8;
  logic [16:0] cnt8;
  logic [24:0] sabs8;
  logic [33:0] ssq8;
  logic [1:0]  st8;

  assign approx8 = '0;

  approx_adder_error_profiler #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .abort(abort8),
    .op_a(op_a8), .op_b(op_b8), .approx_sum(approx8),
    .busy(busy8), .done(done8),
    .err_count(cnt8), .sum_abs_err(sabs8), .sum_sq_err(ssq8),
    .max_abs_err(max8), .worst_a(worst_a8), .worst_b(worst_b8),
    .dbg_state(st8)
  );

  typedef struct {
    string  name;
    bit     zero_base;
    int     n_ovr;
    int     a0, b0, v0, a1, b1, v1;
    longint cnt, sabs, ssq;
    int     mx, wa, wb;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // scoreboard for the six WIDTH=4 metrics
  task automatic check_metrics4(input string p, input longint cnt, input longint sabs,
                                input longint ssq, input int mx, input int wa, input int wb);
    exp_q.push_back(64'(cnt));
    exp_q.push_back(64'(sabs));
    exp_q.push_back(64'(ssq));
    exp_q.push_back(64'(mx));
    exp_q.push_back(64'(wa));
    exp_q.push_back(64'(wb));
    check({p, " err_count"},   64'(cnt4),     exp_q.pop_front());
    check({p, " sum_abs_err"}, 64'(sabs4),    exp_q.pop_front());
    check({p, " sum_sq_err"},  64'(ssq4),     exp_q.pop_front());
    check({p, " max_abs_err"}, 64'(max4),     exp_q.pop_front());
    check({p, " worst_a"},     64'(worst_a4), exp_q.pop_front());
    check({p, " worst_b"},     64'(worst_b4), exp_q.pop_front());
  endtask

  // reference model: walk all pairs in sweep order with plain integer arithmetic
  task automatic ref4(output longint cnt, output longint sabs, output longint ssq,
                      output int mx, output int wa, output int wb);
    int e, ae;
    cnt = 0; sabs = 0; ssq = 0; mx = 0; wa = 0; wb = 0;
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        e  = int'(lut4[b*16+a]) - (a + b);
        ae = (e < 0) ? -e : e;
        if (e != 0) cnt++;
        sabs += ae;
        ssq  += ae * ae;
        if (ae > mx) begin
          mx = ae; wa = a; wb = b;
        end
      end
    end
  endtask

  task automatic build_lut(input bit zero_base);
    for (int i = 0; i < 256; i++) lut4[i] = zero_base ? 5'd0 : 5'((i % 16) + (i / 16));
  endtask

  task automatic random_lut();
    for (int i = 0; i < 256; i++)
      lut4[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'((i % 16) + (i / 16));
  endtask

  // driver: pulse start from a negedge, count edges until done; cycle number = edges + 1
  task automatic run_sweep4(input bit poke, output int cyc);
    int n;
    n = 0;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    while (!done4 && n < 1000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start4 = poke && (n == 50 || n == 120);
    end
    start4 = 1'b0;
    cyc = n + 1;
  endtask

  task automatic check_zero4(input string p);
    check({p, " state"},     64'(st4),   64'd0);
    check({p, " busy"},      64'(busy4), 64'd0);
    check({p, " done"},      64'(done4), 64'd0);
    check({p, " op_a"},      64'(op_a4), 64'd0);
    check({p, " op_b"},      64'(op_b4), 64'd0);
    check_metrics4(p, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test4();
    vec_t   vecs[6];
    int     cyc, n;
    longint c, sa, sq;
    int     mx, wa, wb;

    vecs[0] = '{"exact",   1'b0, 0, 0, 0, 0, 0, 0, 0,   0,    0,     0,  0,  0,  0};
    vecs[1] = '{"one_err", 1'b0, 1, 3, 5, 9, 0, 0, 0,   1,    1,     1,  1,  3,  5};
    vecs[2] = '{"zero",    1'b1, 0, 0, 0, 0, 0, 0, 0,   255,  3840,  68480, 30, 15, 15};
    vecs[3] = '{"tie",     1'b0, 2, 1, 0, 5, 0, 1, 5,   2,    8,     32, 4,  1,  0};
    vecs[4] = '{"under",   1'b0, 1, 2, 2, 0, 0, 0, 0,   1,    4,     16, 4,  2,  2};
    vecs[5] = '{"extreme", 1'b0, 2, 15, 15, 31, 0, 0, 31, 2,  32,    962, 31, 0,  0};

    rst4 = 1'b1; start4 = 1'b0; abort4 = 1'b0;
    build_lut(1'b0);
    repeat (2) @(negedge clk);
    check_zero4("reset4");
    rst4 = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      build_lut(vecs[v].zero_base);
      if (vecs[v].n_ovr > 0) lut4[vecs[v].b0*16 + vecs[v].a0] = 5'(vecs[v].v0);
      if (vecs[v].n_ovr > 1) lut4[vecs[v].b1*16 + vecs[v].a1] = 5'(vecs[v].v1);
      run_sweep4(1'b0, cyc);
      check({vecs[v].name, " done cycle"}, 64'(cyc), 64'd259);
      check({vecs[v].name, " busy"}, 64'(busy4), 64'd0);
      check({vecs[v].name, " op_a hold"}, 64'(op_a4), 64'd15);
      check({vecs[v].name, " op_b hold"}, 64'(op_b4), 64'd15);
      check_metrics4(vecs[v].name, vecs[v].cnt, vecs[v].sabs, vecs[v].ssq,
                     vecs[v].mx, vecs[v].wa, vecs[v].wb);
    end

    for (int r = 0; r < 4; r++) begin
      random_lut();
      ref4(c, sa, sq, mx, wa, wb);
      run_sweep4(1'b0, cyc);
      check($sformatf("rand%0d done cycle", r), 64'(cyc), 64'd259);
      check_metrics4($sformatf("rand%0d", r), c, sa, sq, mx, wa, wb);
    end

    // abort at idx 100, then a full sweep with stray start pulses mid-run
    random_lut();
    ref4(c, sa, sq, mx, wa, wb);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while ({op_b4, op_a4} != 8'd100 && n < 500) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("abort idx reached", 64'(n), 64'd100);
    check("abort busy before", 64'(busy4), 64'd1);
    abort4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort4 = 1'b0;
    check_zero4("after abort");
    run_sweep4(1'b1, cyc);
    check("restart done cycle", 64'(cyc), 64'd259);
    check_metrics4("restart", c, sa, sq, mx, wa, wb);

    // reset mid-run
    random_lut();
    ref4(c, sa, sq, mx, wa, wb);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    repeat (40) @(negedge clk);
    rst4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    check_zero4("mid reset");
    run_sweep4(1'b0, cyc);
    check("post reset done cycle", 64'(cyc), 64'd259);
    check_metrics4("post reset", c, sa, sq, mx, wa, wb);
  endtask

  task automatic test8();
    int n;
    rst8 = 1'b1; start8 = 1'b0; abort8 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset8 done", 64'(done8), 64'd0);
    check("reset8 err_count", 64'(cnt8), 64'd0);
    check("reset8 op_a", 64'(op_a8), 64'd0);
    rst8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 70000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("w8 done cycle", 64'(n + 1), 64'd65539);
    check("w8 busy", 64'(busy8), 64'd0);
    check("w8 err_count", 64'(cnt8), 64'd65535);
    check("w8 sum_abs_err", 64'(sabs8), 64'd16711680);
    check("w8 sum_sq_err", 64'(ssq8), 64'd4977295360);
    check("w8 max_abs_err", 64'(max8), 64'd510);
    check("w8 worst_a", 64'(worst_a8), 64'd255);
    check("w8 worst_b", 64'(worst_b8), 64'd255);
    check("w8 state", 64'(st8), 64'd3);
  endtask

  initial begin
    fork
      test4();
      test8();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
